// File: rtl/io_responder.sv
// CPU IO-port responder: GPIO out/in, UART transmitter with TX FIFO, RX holding register.
// Optional `IO_TIMER_EN adds a free-running cycle counter at 0x3000.
`ifndef WIDTH
`define WIDTH 16
`endif

module io_responder #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [`WIDTH-1:0] io_addr,
    input  logic [`WIDTH-1:0] io_wdata,
    input  logic              io_wr,
    input  logic              io_rd,
    output logic [`WIDTH-1:0] io_rdata,
    output logic [7:0]        gpio_out,
    input  logic [7:0]        gpio_in,
    output logic              uart_tx,
    input  logic [7:0]        rx_byte,
    input  logic              rx_strobe
);
    localparam int W  = `WIDTH;
    localparam int PW = $clog2(TX_FIFO_DEPTH);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(TX_FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [15:0] A_GPIO_OUT = 16'h1000;
    localparam logic [15:0] A_GPIO_IN  = 16'h1001;
    localparam logic [15:0] A_TX_DATA  = 16'h2000;
    localparam logic [15:0] A_STATUS   = 16'h2001;
    localparam logic [15:0] A_RX_DATA  = 16'h2002;
`ifdef IO_TIMER_EN
    localparam logic [15:0] A_TIMER    = 16'h3000;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [15:0]   addr;
    logic          wr_gpio, wr_tx, wr_status, rd_rx;
    logic [7:0]    gpio_sync_p0, gpio_sync_p1;
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty, tx_push, tx_pop;
    tx_state_t     state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_cnt;
    logic          baud_done;
    logic [7:0]    rx_hold;
    logic          rx_valid, rx_overrun, tx_overflow;
    logic          unused_bits;

    assign addr        = io_addr[15:0];
    assign wr_gpio     = io_wr && (addr == A_GPIO_OUT);
    assign wr_tx       = io_wr && (addr == A_TX_DATA);
    assign wr_status   = io_wr && (addr == A_STATUS);
    assign rd_rx       = io_rd && (addr == A_RX_DATA);
    assign fifo_full   = (fifo_cnt == FIFO_FULL);
    assign fifo_empty  = (fifo_cnt == '0);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign tx_push     = wr_tx && !fifo_full;
    assign tx_pop      = (state == S_IDLE) && !fifo_empty;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign unused_bits = ^{io_addr, io_wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out     <= '0;
            gpio_sync_p0 <= '0;
            gpio_sync_p1 <= '0;
        end else begin
            if (wr_gpio) gpio_out <= io_wdata[7:0];
            gpio_sync_p0 <= gpio_in;
            gpio_sync_p1 <= gpio_sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_tx && fifo_full) tx_overflow <= 1'b1;
            else if (wr_status)     tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr] <= io_wdata[7:0];
        if (tx_pop)                        shreg <= fifo_mem[rd_ptr];
        else if (state == S_DATA && baud_done) shreg <= {1'b0, shreg[7:1]};
    end

    // uart_tx follows the state one cycle behind, giving the pop-to-start-bit latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            uart_tx  <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        state    <= S_START;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                    end
                end
                S_START: begin
                    uart_tx <= 1'b0;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    uart_tx <= shreg[0];
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_strobe) rx_hold <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_status) rx_overrun <= 1'b0;
            if (rx_strobe) begin
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rx) rx_overrun <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef IO_TIMER_EN
    logic [W-1:0] timer;
    always_ff @(posedge clk) begin
        if (reset || (io_wr && addr == A_TIMER)) timer <= '0;
        else                                     timer <= timer + W'(1);
    end
`endif

    always_comb begin
        io_rdata = '0;
        case (addr)
            A_GPIO_OUT: io_rdata = W'(gpio_out);
            A_GPIO_IN:  io_rdata = W'(gpio_sync_p1);
            A_STATUS:   io_rdata = W'({rx_overrun, tx_overflow, rx_valid,
                                       (state != S_IDLE), fifo_empty, fifo_full});
            A_RX_DATA:  io_rdata = W'(rx_hold);
`ifdef IO_TIMER_EN
            A_TIMER:    io_rdata = timer;
`endif
            default:    io_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register table plus hand sequences for UART, FIFO and RX corners.
`ifndef WIDTH
`define WIDTH 16
`endif

module tb_io_responder;
    localparam int W = `WIDTH;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] io_addr, io_wdata, io_rdata;
    logic         io_wr, io_rd;
    logic [7:0]   gpio_out, gpio_in, rx_byte;
    logic         uart_tx, rx_strobe;

    int errors = 0;
    int checks = 0;

    logic log_en = 1'b0;
    logic tx_log [$];

    io_responder #(.CLKS_PER_BIT(4), .TX_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_wr(io_wr), .io_rd(io_rd), .io_rdata(io_rdata), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .uart_tx(uart_tx), .rx_byte(rx_byte), .rx_strobe(rx_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (log_en) tx_log.push_back(uart_tx);
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected line level for sample j (0..40) of a frame carrying b, CLKS_PER_BIT=4.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j < 4) return 1'b0;
        if (j < 36) return b[(j - 4) / 4];
        return 1'b1;
    endfunction

    // Log index 0 is the sample after the first TX_DATA write edge; frames begin at index 2.
    task automatic compare_frames(input string name, input logic [7:0] bytes [5], input int n);
        for (int f = 0; f < n; f++) begin
            int bad;
            int first;
            bad = 0;
            first = -1;
            for (int j = 0; j < 41; j++) begin
                int idx;
                idx = 2 + f * 41 + j;
                if (idx >= tx_log.size() || tx_log[idx] !== exp_bit(bytes[f], j)) begin
                    bad++;
                    if (first < 0) first = j;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s frame %0d: got %0d bad samples (first at %0d) expected 0", name, f, bad, first);
            end
        end
        check({name, "_lead"}, {30'b0, tx_log[0], tx_log[1]}, 32'h3);
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        io_addr = a;
        #1;
        check(name, 32'(io_rdata), 32'(exp));
    endtask

    initial begin
        logic [7:0] frames [5];

        vecs[0]  = '{16'h2001, 1'b0, 1'b1, 16'h0000, 16'h0002, 8'h00};
        vecs[1]  = '{16'h1000, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h00};
        vecs[2]  = '{16'h1000, 1'b1, 1'b0, 16'h005A, 16'h0000, 8'h00};
        vecs[3]  = '{16'h1000, 1'b0, 1'b1, 16'h0000, 16'h005A, 8'h5A};
        vecs[4]  = '{16'h1234, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h5A};
        vecs[5]  = '{16'h1234, 1'b1, 1'b0, 16'h00FF, 16'h0000, 8'h5A};
        vecs[6]  = '{16'h1000, 1'b0, 1'b1, 16'h0000, 16'h005A, 8'h5A};
        vecs[7]  = '{16'h2000, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h5A};
        vecs[8]  = '{16'h3000, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h5A};
        vecs[9]  = '{16'h3000, 1'b1, 1'b0, 16'h1234, 16'h0000, 8'h5A};
        vecs[10] = '{16'h1001, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h5A};
        vecs[11] = '{16'h1000, 1'b1, 1'b0, 16'h01FF, 16'h005A, 8'h5A};
        vecs[12] = '{16'h1000, 1'b0, 1'b1, 16'h0000, 16'h00FF, 8'hFF};
        vecs[13] = '{16'h2001, 1'b1, 1'b0, 16'h0000, 16'h0002, 8'hFF};
        vecs[14] = '{16'h2001, 1'b0, 1'b1, 16'h0000, 16'h0002, 8'hFF};

        reset = 1'b1; io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0;
        gpio_in = 8'h00; rx_byte = 8'h00; rx_strobe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_uart_tx", 32'(uart_tx), 32'h1);
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        read_check("reset_status", 16'h2001, 16'h0002);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            io_addr = W'(vecs[i].addr); io_wdata = W'(vecs[i].wdata);
            io_wr = vecs[i].wr; io_rd = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_rdata", i), 32'(io_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
            @(negedge clk);
        end
        io_wr = 1'b0; io_rd = 1'b0;

        // Single 0xA5 frame.
        tx_log.delete();
        log_en = 1'b1;
        write_reg(16'h2000, 16'h00A5);
        @(negedge clk);
        read_check("a5_status_busy", 16'h2001, 16'h0006);
        repeat (45) @(negedge clk);
        log_en = 1'b0;
        frames[0] = 8'hA5;
        compare_frames("a5", frames, 1);
        read_check("a5_status_done", 16'h2001, 16'h0002);

        // Six back-to-back writes into a depth-4 FIFO: 0x06 is dropped.
        tx_log.delete();
        log_en = 1'b1;
        io_addr = 16'h2000; io_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            io_wdata = W'(i + 1);
            @(negedge clk);
        end
        io_wr = 1'b0;
        read_check("ovf_status_full", 16'h2001, 16'h0015);
        repeat (215) @(negedge clk);
        log_en = 1'b0;
        for (int i = 0; i < 5; i++) frames[i] = 8'(i + 1);
        compare_frames("ovf", frames, 5);
        read_check("ovf_status_after", 16'h2001, 16'h0012);
        write_reg(16'h2001, 16'h0000);
        read_check("ovf_status_cleared", 16'h2001, 16'h0002);

        // RX overrun.
        rx_byte = 8'h3C; rx_strobe = 1'b1;
        @(negedge clk);
        rx_byte = 8'h7E;
        @(negedge clk);
        rx_strobe = 1'b0;
        read_check("rx_status_overrun", 16'h2001, 16'h002A);
        io_rd = 1'b1;
        read_check("rx_data_7e", 16'h2002, 16'h007E);
        @(negedge clk);
        io_rd = 1'b0;
        read_check("rx_status_popped", 16'h2001, 16'h0022);
        write_reg(16'h2001, 16'h0000);
        read_check("rx_status_cleared", 16'h2001, 16'h0002);

        // RX strobe and pop in the same cycle.
        rx_byte = 8'h11; rx_strobe = 1'b1;
        @(negedge clk);
        rx_byte = 8'h22; io_rd = 1'b1;
        read_check("race_data_11", 16'h2002, 16'h0011);
        @(negedge clk);
        rx_strobe = 1'b0; io_rd = 1'b0;
        read_check("race_status", 16'h2001, 16'h000A);
        io_rd = 1'b1;
        read_check("race_data_22", 16'h2002, 16'h0022);
        @(negedge clk);
        io_rd = 1'b0;
        read_check("race_status_after", 16'h2001, 16'h0002);

        // Reset in the middle of a zero-byte frame with a second byte queued.
        io_addr = 16'h2000; io_wdata = 16'h0000; io_wr = 1'b1;
        repeat (2) @(negedge clk);
        io_wr = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_frame_tx_low", 32'(uart_tx), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_tx_high", 32'(uart_tx), 32'h1);
        check("mid_reset_gpio", 32'(gpio_out), 32'h0);
        read_check("mid_reset_status", 16'h2001, 16'h0002);
        repeat (5) @(negedge clk);
        check("mid_reset_tx_stays", 32'(uart_tx), 32'h1);

        write_reg(16'h1000, 16'h005A);
        check("gpio_out_5a", 32'(gpio_out), 32'h5A);
        gpio_in = 8'hC3;
        read_check("gpio_in_0cyc", 16'h1001, 16'h0000);
        @(negedge clk);
        read_check("gpio_in_1cyc", 16'h1001, 16'h0000);
        @(negedge clk);
        read_check("gpio_in_2cyc", 16'h1001, 16'h00C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
